// File: rtl/ctrl_pipe_hazard.sv
// Control-signal pipeline D->E->M->W with per-stage stall/flush, valid tracking
// and saturating stall/flush/retire performance counters.
module ctrl_pipe_hazard #(
  parameter int ALUCTRL_W = 4,
  parameter int RESSRC_W  = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Valid_D,
  input  logic                 RegWrite_D,
  input  logic                 MemWrite_D,
  input  logic                 Jump_D,
  input  logic                 Branch_D,
  input  logic                 ALUSrc_D,
  input  logic [RESSRC_W-1:0]  ResultSrc_D,
  input  logic [ALUCTRL_W-1:0] ALUControl_D,
  input  logic                 Stall_E,
  input  logic                 Flush_E,
  input  logic                 Stall_M,
  input  logic                 Flush_M,
  input  logic                 cnt_clr,
  output logic                 Valid_E,
  output logic                 RegWrite_E,
  output logic                 MemWrite_E,
  output logic                 Jump_E,
  output logic                 Branch_E,
  output logic                 ALUSrc_E,
  output logic [RESSRC_W-1:0]  ResultSrc_E,
  output logic [ALUCTRL_W-1:0] ALUControl_E,
  output logic                 Valid_M,
  output logic                 RegWrite_M,
  output logic                 MemWrite_M,
  output logic [RESSRC_W-1:0]  ResultSrc_M,
  output logic                 Valid_W,
  output logic                 RegWrite_W,
  output logic [RESSRC_W-1:0]  ResultSrc_W,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic [CNT_W-1:0]     retire_cnt
);

  logic                 valid_e_q, regwrite_e_q, memwrite_e_q, jump_e_q, branch_e_q, alusrc_e_q;
  logic [RESSRC_W-1:0]  ressrc_e_q;
  logic [ALUCTRL_W-1:0] aluctrl_e_q;
  logic                 valid_m_q, regwrite_m_q, memwrite_m_q;
  logic [RESSRC_W-1:0]  ressrc_m_q;
  logic                 valid_w_q, regwrite_w_q;
  logic [RESSRC_W-1:0]  ressrc_w_q;
  logic [CNT_W-1:0]     stall_q, stall_d, flush_q, flush_d, retire_q, retire_d;

  logic stall_e_eff;
  assign stall_e_eff = Stall_E | Stall_M;

  always_ff @(posedge clk) begin
    if (!rst_n || Flush_E) begin
      valid_e_q    <= 1'b0;
      regwrite_e_q <= 1'b0;
      memwrite_e_q <= 1'b0;
      jump_e_q     <= 1'b0;
      branch_e_q   <= 1'b0;
      alusrc_e_q   <= 1'b0;
      ressrc_e_q   <= '0;
      aluctrl_e_q  <= '0;
    end else if (!stall_e_eff) begin
      valid_e_q    <= Valid_D;
      regwrite_e_q <= RegWrite_D;
      memwrite_e_q <= MemWrite_D;
      jump_e_q     <= Jump_D;
      branch_e_q   <= Branch_D;
      alusrc_e_q   <= ALUSrc_D;
      ressrc_e_q   <= ResultSrc_D;
      aluctrl_e_q  <= ALUControl_D;
    end
  end

  // E held while M is free: M takes a bubble so the held instruction is not duplicated.
  always_ff @(posedge clk) begin
    if (!rst_n || Flush_M || (stall_e_eff && !Stall_M)) begin
      valid_m_q    <= 1'b0;
      regwrite_m_q <= 1'b0;
      memwrite_m_q <= 1'b0;
      ressrc_m_q   <= '0;
    end else if (!Stall_M) begin
      valid_m_q    <= valid_e_q;
      regwrite_m_q <= regwrite_e_q;
      memwrite_m_q <= memwrite_e_q;
      ressrc_m_q   <= ressrc_e_q;
    end
  end

  // A frozen M must not retire twice, so W sees bubbles while Stall_M is high.
  always_ff @(posedge clk) begin
    if (!rst_n || Stall_M) begin
      valid_w_q    <= 1'b0;
      regwrite_w_q <= 1'b0;
      ressrc_w_q   <= '0;
    end else begin
      valid_w_q    <= valid_m_q;
      regwrite_w_q <= regwrite_m_q;
      ressrc_w_q   <= ressrc_m_q;
    end
  end

  always_comb begin
    stall_d  = stall_q;
    flush_d  = flush_q;
    retire_d = retire_q;
    if (cnt_clr) begin
      stall_d  = '0;
      flush_d  = '0;
      retire_d = '0;
    end else begin
      if (stall_e_eff && (stall_q != '1))          stall_d  = stall_q + CNT_W'(1);
      if ((Flush_E || Flush_M) && (flush_q != '1)) flush_d  = flush_q + CNT_W'(1);
      if (valid_w_q && (retire_q != '1))           retire_d = retire_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q  <= '0;
      flush_q  <= '0;
      retire_q <= '0;
    end else begin
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      retire_q <= retire_d;
    end
  end

  assign Valid_E      = valid_e_q;
  assign RegWrite_E   = regwrite_e_q;
  assign MemWrite_E   = memwrite_e_q;
  assign Jump_E       = jump_e_q;
  assign Branch_E     = branch_e_q;
  assign ALUSrc_E     = alusrc_e_q;
  assign ResultSrc_E  = ressrc_e_q;
  assign ALUControl_E = aluctrl_e_q;
  assign Valid_M      = valid_m_q;
  assign RegWrite_M   = regwrite_m_q;
  assign MemWrite_M   = memwrite_m_q;
  assign ResultSrc_M  = ressrc_m_q;
  assign Valid_W      = valid_w_q;
  assign RegWrite_W   = regwrite_w_q;
  assign ResultSrc_W  = ressrc_w_q;
  assign stall_cnt    = stall_q;
  assign flush_cnt    = flush_q;
  assign retire_cnt   = retire_q;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Self-checking bench: directed hazard scenarios plus random traffic against a
// stage-level reference model; a second instance with CNT_W=2 checks saturation.
module tb_ctrl_pipe_hazard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall_e, flush_e, stall_m, flush_m, clr;
  // D bundle: {Valid, RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc[1:0], ALUControl[3:0]}
  logic [11:0] d;

  logic        vE, rwE, mwE, jE, bE, asE, vM, rwM, mwM, vW, rwW;
  logic [1:0]  rsE, rsM, rsW;
  logic [3:0]  aluE;
  logic [15:0] scnt, fcnt, rcnt;

  logic        vE2, rwE2, mwE2, jE2, bE2, asE2, vM2, rwM2, mwM2, vW2, rwW2;
  logic [1:0]  rsE2, rsM2, rsW2;
  logic [3:0]  aluE2;
  logic [1:0]  scnt2, fcnt2, rcnt2;

  ctrl_pipe_hazard #(.ALUCTRL_W(4), .RESSRC_W(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .Valid_D(d[11]), .RegWrite_D(d[10]), .MemWrite_D(d[9]), .Jump_D(d[8]),
    .Branch_D(d[7]), .ALUSrc_D(d[6]), .ResultSrc_D(d[5:4]), .ALUControl_D(d[3:0]),
    .Stall_E(stall_e), .Flush_E(flush_e), .Stall_M(stall_m), .Flush_M(flush_m),
    .cnt_clr(clr),
    .Valid_E(vE), .RegWrite_E(rwE), .MemWrite_E(mwE), .Jump_E(jE), .Branch_E(bE),
    .ALUSrc_E(asE), .ResultSrc_E(rsE), .ALUControl_E(aluE),
    .Valid_M(vM), .RegWrite_M(rwM), .MemWrite_M(mwM), .ResultSrc_M(rsM),
    .Valid_W(vW), .RegWrite_W(rwW), .ResultSrc_W(rsW),
    .stall_cnt(scnt), .flush_cnt(fcnt), .retire_cnt(rcnt)
  );

  ctrl_pipe_hazard #(.ALUCTRL_W(4), .RESSRC_W(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .Valid_D(d[11]), .RegWrite_D(d[10]), .MemWrite_D(d[9]), .Jump_D(d[8]),
    .Branch_D(d[7]), .ALUSrc_D(d[6]), .ResultSrc_D(d[5:4]), .ALUControl_D(d[3:0]),
    .Stall_E(stall_e), .Flush_E(flush_e), .Stall_M(stall_m), .Flush_M(flush_m),
    .cnt_clr(clr),
    .Valid_E(vE2), .RegWrite_E(rwE2), .MemWrite_E(mwE2), .Jump_E(jE2), .Branch_E(bE2),
    .ALUSrc_E(asE2), .ResultSrc_E(rsE2), .ALUControl_E(aluE2),
    .Valid_M(vM2), .RegWrite_M(rwM2), .MemWrite_M(mwM2), .ResultSrc_M(rsM2),
    .Valid_W(vW2), .RegWrite_W(rwW2), .ResultSrc_W(rsW2),
    .stall_cnt(scnt2), .flush_cnt(fcnt2), .retire_cnt(rcnt2)
  );

  // Reference state: one instruction record per stage, counters as plain integers.
  typedef struct {
    bit       v, rw, mw, j, b, as;
    bit [1:0] rs;
    bit [3:0] alu;
  } instr_t;

  instr_t      ex, mem, wb;
  int unsigned n_stall, n_flush, n_retire;
  int unsigned checks = 0;
  int unsigned passed = 0;

  function automatic instr_t from_d(logic [11:0] v);
    instr_t r;
    r.v = v[11]; r.rw = v[10]; r.mw = v[9]; r.j = v[8];
    r.b = v[7];  r.as = v[6];  r.rs = v[5:4]; r.alu = v[3:0];
    return r;
  endfunction

  function automatic instr_t bubble();
    instr_t r;
    r = '{default: 0};
    return r;
  endfunction

  // Only the fields that travel on into a later stage survive the hop.
  function automatic instr_t narrow_to_m(instr_t r);
    instr_t o;
    o = bubble();
    o.v = r.v; o.rw = r.rw; o.mw = r.mw; o.rs = r.rs;
    return o;
  endfunction

  function automatic instr_t narrow_to_w(instr_t r);
    instr_t o;
    o = bubble();
    o.v = r.v; o.rw = r.rw; o.rs = r.rs;
    return o;
  endfunction

  function automatic int unsigned sat(int unsigned x, int unsigned mx);
    return (x + 1 > mx) ? mx : x + 1;
  endfunction

  function automatic int unsigned clip(int unsigned x, int unsigned mx);
    return (x > mx) ? mx : x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    check("E",  {20'd0, vE, rwE, mwE, jE, bE, asE, rsE, aluE},
                {20'd0, ex.v, ex.rw, ex.mw, ex.j, ex.b, ex.as, ex.rs, ex.alu});
    check("M",  {27'd0, vM, rwM, mwM, rsM}, {27'd0, mem.v, mem.rw, mem.mw, mem.rs});
    check("W",  {28'd0, vW, rwW, rsW}, {28'd0, wb.v, wb.rw, wb.rs});
    check("stall_cnt",  {16'd0, scnt}, clip(n_stall, 65535));
    check("flush_cnt",  {16'd0, fcnt}, clip(n_flush, 65535));
    check("retire_cnt", {16'd0, rcnt}, clip(n_retire, 65535));
    check("E_sat", {20'd0, vE2, rwE2, mwE2, jE2, bE2, asE2, rsE2, aluE2},
                   {20'd0, vE, rwE, mwE, jE, bE, asE, rsE, aluE} & 32'hFFF);
    check("W_sat", {28'd0, vW2, rwW2, rsW2}, {28'd0, wb.v, wb.rw, wb.rs});
    check("stall_cnt_sat",  {30'd0, scnt2}, clip(n_stall, 3));
    check("flush_cnt_sat",  {30'd0, fcnt2}, clip(n_flush, 3));
    check("retire_cnt_sat", {30'd0, rcnt2}, clip(n_retire, 3));
  endtask

  // Counters in the model saturate at the 16-bit limit; the 2-bit view is clipped at compare time.
  task automatic step();
    instr_t ne, nm, nw;
    bit     held_e;
    @(posedge clk);
    if (!rst_n) begin
      ex = bubble(); mem = bubble(); wb = bubble();
      n_stall = 0; n_flush = 0; n_retire = 0;
    end else begin
      held_e = stall_e || stall_m;
      if (clr) begin
        n_stall = 0; n_flush = 0; n_retire = 0;
      end else begin
        if (held_e)             n_stall  = sat(n_stall, 65535);
        if (flush_e || flush_m) n_flush  = sat(n_flush, 65535);
        if (wb.v)               n_retire = sat(n_retire, 65535);
      end
      if (flush_e)     ne = bubble();
      else if (held_e) ne = ex;
      else             ne = from_d(d);
      if (flush_m)      nm = bubble();
      else if (stall_m) nm = mem;
      else if (held_e)  nm = bubble();
      else              nm = narrow_to_m(ex);
      nw = stall_m ? bubble() : narrow_to_w(mem);
      ex = ne; mem = nm; wb = nw;
    end
    #1;
    check_all();
  endtask

  task automatic hz(input bit se, input bit fe, input bit sm, input bit fm, input bit c);
    stall_e = se; flush_e = fe; stall_m = sm; flush_m = fm; clr = c;
  endtask

  initial begin
    ex = bubble(); mem = bubble(); wb = bubble();
    n_stall = 0; n_flush = 0; n_retire = 0;
    rst_n = 1'b0; d = 12'($urandom); hz(0, 0, 0, 0, 0);

    // Reset held with random D and random hazard inputs
    for (int i = 0; i < 3; i++) begin
      d = 12'($urandom);
      hz(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
      step();
    end
    check("reset_valid_E", {31'd0, vE}, 32'd0);
    check("reset_retire",  {16'd0, rcnt}, 32'd0);

    // Release: {Valid=1, RegWrite=1, ALUControl=0110} lands on E one edge later
    rst_n = 1'b1; hz(0, 0, 0, 0, 0);
    d = 12'hC06;
    step();
    check("release_valid_E",  {31'd0, vE}, 32'd1);
    check("release_aluctl_E", {28'd0, aluE}, 32'd6);

    // Straight flow: 4 valid instructions, then drain
    for (int i = 0; i < 4; i++) begin
      d = {1'b1, 11'($urandom)};
      step();
    end
    d = '0;
    for (int i = 0; i < 4; i++) step();

    // Load-use stall for one cycle
    d = {1'b1, 11'($urandom)}; step();
    d = {1'b1, 11'($urandom)}; hz(1, 0, 0, 0, 0); step();
    check("loaduse_bubble_M", {30'd0, vM, rwM}, 32'd0);
    hz(0, 0, 0, 0, 0); step(); step();

    // Flush and stall together on E: flush wins
    d = {1'b1, 11'($urandom)}; hz(1, 1, 0, 0, 0); step();
    check("flush_over_stall_E", {31'd0, vE}, 32'd0);
    hz(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin d = {1'b1, 11'($urandom)}; step(); end

    // M stall for two cycles: W takes bubbles, no duplicate retire
    hz(0, 0, 1, 0, 0); step(); step();
    hz(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin d = {1'b1, 11'($urandom)}; step(); end

    // Saturation on the 2-bit instance, then clear racing an active stall
    hz(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    check("sat_stall_2bit", {30'd0, scnt2}, 32'd3);
    hz(1, 0, 0, 0, 1); step();
    check("clr_beats_inc", {30'd0, scnt2}, 32'd0);
    hz(0, 0, 0, 0, 0); step();

    // Random traffic with occasional hazards, clears and resets
    for (int i = 0; i < 400; i++) begin
      d = 12'($urandom);
      hz($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
         $urandom_range(0, 6) == 0, $urandom_range(0, 7) == 0,
         $urandom_range(0, 50) == 0);
      rst_n = ($urandom_range(0, 60) != 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
